// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse cipher.
package aes_pkg;

  typedef logic [3:0][3:0][7:0] aes_state_t;  // [row][col] bytes

  typedef enum logic [1:0] {
    StIdle,
    StKeyWait,
    StDone
  } aes_fsm_e;

  localparam logic [3:0] ROUND_FIRST = 4'd10;
  localparam logic [3:0] ROUND_LAST  = 4'd0;

  // Element 0 is the leftmost byte of the first chunk.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Row r rotated right by r byte positions.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r][c] = s[r][2'(c - r)];
      end
    end
    return o;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r][c] = gf_mul(8'h0e, s[r][c]) ^ gf_mul(8'h0b, s[2'(r + 1)][c]) ^
                  gf_mul(8'h0d, s[2'(r + 2)][c]) ^ gf_mul(8'h09, s[2'(r + 3)][c]);
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_de_core_if.sv
// Job control, key-expansion handshake and result bus of the decryption core.
interface aes_de_core_if;
  import aes_pkg::*;

  logic       aes_core_en;
  aes_state_t cipher_text_i;
  aes_state_t round_key_i;
  logic       key_vld_i;
  logic       key_req_o;
  logic [3:0] key_sel_o;
  logic       plain_text_rdy_o;
  aes_state_t plain_text_o;
  logic       busy_o;

  modport slave (
    input  aes_core_en, cipher_text_i, round_key_i, key_vld_i,
    output key_req_o, key_sel_o, plain_text_rdy_o, plain_text_o, busy_o
  );

  modport master (
    output aes_core_en, cipher_text_i, round_key_i, key_vld_i,
    input  key_req_o, key_sel_o, plain_text_rdy_o, plain_text_o, busy_o
  );
endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational single-byte AES inverse S-box.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  assign data_o = INV_SBOX[data_i];
endmodule

// File: rtl/aes_de_core.sv
// Iterative AES-128 decryption: one inverse round per accepted round key, keys 10 down to 0.
module aes_de_core
  import aes_pkg::*;
#(
  parameter int unsigned NO_ROWS = 4,
  parameter int unsigned NO_COLS = 4
) (
  input logic         aes_clk,
  input logic         resetn,
  aes_de_core_if.slave bus
);

  aes_fsm_e   st_q;
  aes_state_t state_q;
  logic [3:0] round_q;
  logic       key_req_q;
  logic       busy_q;
  logic       rdy_q;
  aes_state_t pt_q;

  aes_state_t isr;
  aes_state_t isb;
  aes_state_t ark;
  aes_state_t imc;

  assign isr = inv_shift_rows(state_q);

  for (genvar r = 0; r < NO_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NO_COLS; c++) begin : g_col
      aes_inv_sbox u_inv_sbox (
        .data_i (isr[r][c]),
        .data_o (isb[r][c])
      );
    end
  end

  assign ark = isb ^ bus.round_key_i;
  assign imc = inv_mix_columns(ark);

  // Enable low acts as a synchronous abort from any state.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      st_q      <= StIdle;
      state_q   <= '0;
      round_q   <= '0;
      key_req_q <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      pt_q      <= '0;
    end else if (!bus.aes_core_en) begin
      st_q      <= StIdle;
      state_q   <= '0;
      round_q   <= '0;
      key_req_q <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      pt_q      <= '0;
    end else begin
      unique case (st_q)
        StIdle: begin
          state_q   <= bus.cipher_text_i;
          round_q   <= ROUND_FIRST;
          key_req_q <= 1'b1;
          busy_q    <= 1'b1;
          st_q      <= StKeyWait;
        end
        StKeyWait: begin
          if (bus.key_vld_i) begin
            if (round_q == ROUND_FIRST) begin
              state_q <= state_q ^ bus.round_key_i;
            end else if (round_q == ROUND_LAST) begin
              pt_q      <= ark;
              rdy_q     <= 1'b1;
              key_req_q <= 1'b0;
              busy_q    <= 1'b0;
              st_q      <= StDone;
            end else begin
              state_q <= imc;
            end
            if (round_q != ROUND_LAST) round_q <= round_q - 4'd1;
          end
        end
        StDone: begin
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign bus.key_req_o        = key_req_q;
  assign bus.key_sel_o        = round_q;
  assign bus.busy_o           = busy_q;
  assign bus.plain_text_rdy_o = rdy_q;
  assign bus.plain_text_o     = pt_q;

endmodule

// File: tb/tb_aes_de_core.sv
// Directed FIPS-197 vectors against aes_de_core, with stalls, abort and reset scenarios.
module tb_aes_de_core;
  import aes_pkg::*;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic aes_clk = 1'b0;
  logic resetn  = 1'b0;
  always #5 aes_clk = ~aes_clk;

  aes_de_core_if bus_if ();

  aes_de_core #(
    .NO_ROWS (4),
    .NO_COLS (4)
  ) dut (
    .aes_clk (aes_clk),
    .resetn  (resetn),
    .bus     (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] rk [2][11];
  int           sel_log [64];
  bit           req_log [64];
  bit           vld_log [64];

  function automatic aes_state_t to_mat(input logic [127:0] b);
    aes_state_t m;
    for (int n = 0; n < 16; n++) m[n % 4][n / 4] = b[127 - 8 * n -: 8];
    return m;
  endfunction

  function automatic logic [127:0] to_blk(input aes_state_t m);
    logic [127:0] b;
    for (int n = 0; n < 16; n++) b[127 - 8 * n -: 8] = m[n % 4][n / 4];
    return b;
  endfunction

  // Starts a job at the current falling edge and acts as the key-expansion block.
  // Cycle 1 is the first falling edge after the start is sampled.
  task automatic run_job(input logic [127:0] ct, input int kset, input bit stalls,
                         input int stop_sel, input bit ct_change,
                         output logic [127:0] pt, output int rdy_cyc, output bit stopped);
    int cyc;
    rdy_cyc = -1;
    stopped = 1'b0;
    pt      = '0;
    cyc     = 0;
    for (int i = 0; i < 64; i++) begin
      sel_log[i] = -1;
      req_log[i] = 1'b0;
      vld_log[i] = 1'b0;
    end
    bus_if.cipher_text_i = to_mat(ct);
    bus_if.aes_core_en   = 1'b1;
    bus_if.key_vld_i     = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge aes_clk);
      cyc++;
      sel_log[cyc] = int'(bus_if.key_sel_o);
      req_log[cyc] = bus_if.key_req_o;
      if (bus_if.plain_text_rdy_o) begin
        rdy_cyc          = cyc;
        pt               = to_blk(bus_if.plain_text_o);
        bus_if.key_vld_i = 1'b0;
        break;
      end
      if (bus_if.key_req_o && int'(bus_if.key_sel_o) == stop_sel) begin
        stopped = 1'b1;
        break;
      end
      if (ct_change && cyc == 4) bus_if.cipher_text_i = to_mat(~ct);
      bus_if.key_vld_i   = stalls ? ((cyc % 3 != 0) && ($urandom_range(0, 3) != 0)) : 1'b1;
      vld_log[cyc]       = bus_if.key_vld_i;
      bus_if.round_key_i = to_mat(rk[kset][bus_if.key_sel_o]);
    end
  endtask

  task automatic end_job();
    bus_if.aes_core_en = 1'b0;
    bus_if.key_vld_i   = 1'b0;
    @(negedge aes_clk);
  endtask

  task automatic test_reset();
    resetn               = 1'b0;
    bus_if.aes_core_en   = 1'b0;
    bus_if.key_vld_i     = 1'b0;
    bus_if.cipher_text_i = '0;
    bus_if.round_key_i   = '0;
    repeat (2) @(negedge aes_clk);
    n_cmp++;
    if ({bus_if.key_req_o, bus_if.busy_o, bus_if.plain_text_rdy_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000",
               {bus_if.key_req_o, bus_if.busy_o, bus_if.plain_text_rdy_o});
    end
    n_cmp++;
    if (bus_if.key_sel_o !== 4'd0) begin
      n_err++;
      $display("FAIL reset_sel: got %0d want 0", bus_if.key_sel_o);
    end
    n_cmp++;
    if (to_blk(bus_if.plain_text_o) !== 128'h0) begin
      n_err++;
      $display("FAIL reset_pt: got %h want 0", to_blk(bus_if.plain_text_o));
    end
    resetn = 1'b1;
    @(negedge aes_clk);
  endtask

  task automatic test_c1_tied();
    logic [127:0] pt;
    int           rdy;
    bit           stp;
    run_job(C1_CT, 0, 1'b0, -1, 1'b0, pt, rdy, stp);
    n_cmp++;
    if (pt !== C1_PT) begin
      n_err++;
      $display("FAIL c1_pt: got %h want %h", pt, C1_PT);
    end
    n_cmp++;
    if (rdy !== 12) begin
      n_err++;
      $display("FAIL c1_latency: got %0d want 12", rdy);
    end
    for (int c = 1; c <= 11; c++) begin
      n_cmp++;
      if (!req_log[c] || sel_log[c] !== 11 - c) begin
        n_err++;
        $display("FAIL c1_sel cyc %0d: got req %0d sel %0d want req 1 sel %0d",
                 c, req_log[c], sel_log[c], 11 - c);
      end
    end
    n_cmp++;
    if (req_log[12] !== 1'b0 || bus_if.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL c1_req_fall: got req %0d busy %0d want 0 0", req_log[12], bus_if.busy_o);
    end
    repeat (3) @(negedge aes_clk);
    n_cmp++;
    if (bus_if.plain_text_rdy_o !== 1'b1 || to_blk(bus_if.plain_text_o) !== C1_PT) begin
      n_err++;
      $display("FAIL c1_hold: got rdy %0d pt %h want 1 %h",
               bus_if.plain_text_rdy_o, to_blk(bus_if.plain_text_o), C1_PT);
    end
    end_job();
    n_cmp++;
    if (bus_if.plain_text_rdy_o !== 1'b0 || to_blk(bus_if.plain_text_o) !== 128'h0) begin
      n_err++;
      $display("FAIL c1_release: got rdy %0d pt %h want 0 0",
               bus_if.plain_text_rdy_o, to_blk(bus_if.plain_text_o));
    end
  endtask

  task automatic test_stalls();
    logic [127:0] pt;
    int           rdy;
    bit           stp;
    int           exp_sel;
    int           n_stall;
    run_job(B_CT, 1, 1'b1, -1, 1'b0, pt, rdy, stp);
    n_cmp++;
    if (pt !== B_PT) begin
      n_err++;
      $display("FAIL stall_pt: got %h want %h", pt, B_PT);
    end
    exp_sel = 10;
    n_stall = 0;
    for (int c = 1; c < rdy; c++) begin
      n_cmp++;
      if (!req_log[c] || sel_log[c] !== exp_sel) begin
        n_err++;
        $display("FAIL stall_sel cyc %0d: got req %0d sel %0d want req 1 sel %0d",
                 c, req_log[c], sel_log[c], exp_sel);
      end
      if (vld_log[c]) exp_sel--;
      else n_stall++;
    end
    n_cmp++;
    if (rdy !== 12 + n_stall) begin
      n_err++;
      $display("FAIL stall_latency: got %0d want %0d", rdy, 12 + n_stall);
    end
    end_job();
  endtask

  task automatic test_abort();
    logic [127:0] pt;
    int           rdy;
    bit           stp;
    run_job(C1_CT, 0, 1'b0, 5, 1'b0, pt, rdy, stp);
    n_cmp++;
    if (stp !== 1'b1) begin
      n_err++;
      $display("FAIL abort_reach_sel5: got %0d want 1", stp);
    end
    end_job();
    n_cmp++;
    if ({bus_if.key_req_o, bus_if.busy_o, bus_if.plain_text_rdy_o} !== 3'b000 ||
        to_blk(bus_if.plain_text_o) !== 128'h0) begin
      n_err++;
      $display("FAIL abort_clear: got req/busy/rdy %b pt %h want 000 0",
               {bus_if.key_req_o, bus_if.busy_o, bus_if.plain_text_rdy_o},
               to_blk(bus_if.plain_text_o));
    end
    run_job(C1_CT, 0, 1'b0, -1, 1'b0, pt, rdy, stp);
    n_cmp++;
    if (pt !== C1_PT || rdy !== 12) begin
      n_err++;
      $display("FAIL abort_rerun: got pt %h cyc %0d want %h 12", pt, rdy, C1_PT);
    end
    end_job();
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt;
    int           rdy;
    bit           stp;
    run_job(C1_CT, 0, 1'b0, 3, 1'b0, pt, rdy, stp);
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (stp !== 1'b1 ||
        {bus_if.key_req_o, bus_if.busy_o, bus_if.plain_text_rdy_o} !== 3'b000 ||
        bus_if.key_sel_o !== 4'd0 || to_blk(bus_if.plain_text_o) !== 128'h0) begin
      n_err++;
      $display("FAIL rst_mid: got stop %0d req/busy/rdy %b sel %0d pt %h want 1 000 0 0", stp,
               {bus_if.key_req_o, bus_if.busy_o, bus_if.plain_text_rdy_o},
               bus_if.key_sel_o, to_blk(bus_if.plain_text_o));
    end
    bus_if.aes_core_en = 1'b0;
    bus_if.key_vld_i   = 1'b0;
    @(negedge aes_clk);
    resetn = 1'b1;
    @(negedge aes_clk);
    run_job(C1_CT, 0, 1'b0, -1, 1'b0, pt, rdy, stp);
    n_cmp++;
    if (pt !== C1_PT || rdy !== 12) begin
      n_err++;
      $display("FAIL rst_rerun: got pt %h cyc %0d want %h 12", pt, rdy, C1_PT);
    end
    end_job();
  endtask

  task automatic test_idle_noise();
    logic [127:0] pt;
    int           rdy;
    bit           stp;
    for (int i = 0; i < 4; i++) begin
      bus_if.key_vld_i   = i[0];
      bus_if.round_key_i = to_mat({$urandom, $urandom, $urandom, $urandom});
      @(negedge aes_clk);
      n_cmp++;
      if ({bus_if.key_req_o, bus_if.busy_o, bus_if.plain_text_rdy_o} !== 3'b000) begin
        n_err++;
        $display("FAIL idle_noise %0d: got req/busy/rdy %b want 000", i,
                 {bus_if.key_req_o, bus_if.busy_o, bus_if.plain_text_rdy_o});
      end
    end
    run_job(C1_CT, 0, 1'b0, -1, 1'b1, pt, rdy, stp);
    n_cmp++;
    if (pt !== C1_PT || rdy !== 12) begin
      n_err++;
      $display("FAIL ct_change: got pt %h cyc %0d want %h 12", pt, rdy, C1_PT);
    end
    end_job();
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt;
    int           rdy;
    bit           stp;
    run_job(C1_CT, 0, 1'b0, -1, 1'b0, pt, rdy, stp);
    n_cmp++;
    if (pt !== C1_PT) begin
      n_err++;
      $display("FAIL b2b_first: got %h want %h", pt, C1_PT);
    end
    end_job();
    n_cmp++;
    if (bus_if.plain_text_rdy_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap_rdy: got %0d want 0", bus_if.plain_text_rdy_o);
    end
    run_job(B_CT, 1, 1'b0, -1, 1'b0, pt, rdy, stp);
    n_cmp++;
    if (pt !== B_PT || rdy !== 12) begin
      n_err++;
      $display("FAIL b2b_second: got pt %h cyc %0d want %h 12", pt, rdy, B_PT);
    end
    end_job();
  endtask

  initial begin
    rk[0][0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk[0][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk[0][2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk[0][3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk[0][4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk[0][5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk[0][6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk[0][7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk[0][8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk[0][9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk[0][10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    rk[1][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[1][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[1][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[1][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[1][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[1][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[1][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[1][8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[1][9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[1][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_c1_tied();
    test_stalls();
    test_abort();
    test_reset_mid();
    test_idle_noise();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_de_core.md
# aes_de_core

Iterative AES-128 decryption core, the inverse-cipher counterpart of the encryption core in the crypto processor. Captures a 4x4 cipher-text byte matrix, requests round keys 10 down to 0 from the shared key-expansion block over the existing key_req/key_sel/key_vld handshake, and performs one inverse round per accepted key. Produces the 4x4 plain-text matrix and holds it with a ready flag until the enable drops.

## Interface
- NO_ROWS, 4, state matrix rows (only 4 supported)
- NO_COLS, 4, state matrix columns (only 4 supported)
- aes_clk  in  1  clock; one clock domain
- resetn  in  1  reset, asynchronous, active-low
- aes_core_en  in  1  level enable; rising into IDLE starts a job, low aborts
- cipher_text_i  in  8x[4][4]  cipher-text matrix [row][col], sampled at start only
- round_key_i  in  8x[4][4]  round key for key_sel_o, valid when key_vld_i high
- key_vld_i  in  1  round key valid
- key_req_o  out  1  round key request
- key_sel_o  out  4  requested round index (10..0)
- plain_text_rdy_o  out  1  plain_text_o valid
- plain_text_o  out  8x[4][4]  plain-text matrix
- busy_o  out  1  job in progress (KEY_WAIT)

## Operation
- Byte mapping: block byte n sits at [n%4][n/4].
- FSM states: IDLE, KEY_WAIT, DONE.
- IDLE: aes_core_en high -> state register <= cipher_text_i, round counter <= 10, go to KEY_WAIT.
- KEY_WAIT: key_req_o=1, key_sel_o=round counter. A cycle with key_vld_i high is a key acceptance:
  - round 10: state <= state ^ K10.
  - rounds 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ Kr).
  - round 0: plain_text_o <= InvSubBytes(InvShiftRows(state)) ^ K0, go to DONE.
  - otherwise decrement round counter.
- key_vld_i low: hold; key_sel_o and state unchanged (stall any length).
- InvShiftRows: row r rotated right by r bytes. InvMixColumns matrix rows {0e,0b,0d,09} rotated; GF(2^8) multiply via xtime, reduction polynomial 0x11b. All arithmetic 8-bit, no carries.
- DONE: plain_text_rdy_o=1, plain_text_o held; aes_core_en low -> IDLE.
- aes_core_en low in any state -> IDLE next cycle; key_req_o, busy_o, plain_text_rdy_o cleared, plain_text_o cleared to 0, partial state discarded.
- key_vld_i outside KEY_WAIT ignored. cipher_text_i changes after start ignored.

## Timing
- Reset values: key_req_o 0, key_sel_o 0, busy_o 0, plain_text_rdy_o 0, plain_text_o all 0; FSM IDLE.
- Cycle 0: start sampled. Cycle 1: key_req_o=1, key_sel_o=10.
- With key_vld_i tied high: one round per cycle, key_sel_o 10..0 on cycles 1..11, plain_text_rdy_o high from cycle 12. Latency = 11 + total stall cycles + 1.
- Outputs registered; no combinational path from inputs to outputs.
- key_req_o falls the cycle after the K0 acceptance. New job needs aes_core_en low for at least one cycle.
- resetn assertion mid-job: immediate return to reset values, no completion.

## Structure
- Package aes_pkg: state matrix typedef (8-bit [4][4]), FSM state enum, round constants (ROUND_FIRST=10, ROUND_LAST=0), inverse S-box table, xtime and gf_mul functions.
- Sub-module aes_inv_sbox: combinational byte inverse S-box lookup, instantiated 16x; InvShiftRows/InvMixColumns as package functions.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, key_vld_i tied high -> pt 00112233445566778899aabbccddeeff, key_sel_o 10..0 on cycles 1..11, rdy at cycle 12.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32, random key_vld_i stalls -> pt 3243f6a8885a308d313198a2e0370734, key_sel_o stable during stalls.
- Abort: drop aes_core_en at key_sel_o=5 -> next cycle key_req_o=0, busy_o=0, plain_text_o all 0; rerun C.1 -> correct pt.
- resetn low at key_sel_o=3 -> all outputs at reset values immediately; rerun correct.
- key_vld_i pulses while IDLE and cipher_text_i changed mid-job -> no effect, C.1 result unchanged.
- Back-to-back C.1 then App. B with one-cycle enable gap -> both correct, rdy drops during gap.
